axis_axil_master: RTL and testbench
===================================

Name: axis_axil_master

Overview:
- Downstream stage of the AXI-Lite-to-AXI-Stream bridge: consumes its request packets and replays each one as a single AXI-Lite master transaction on the local user bus.
- Read data returns as a one-beat AXI-Stream completion toward the bridge/IO serdes.
- Exactly one transaction is outstanding at a time; the input stream is back-pressured while busy.

Parameters:
- ADDR_WIDTH, 15, AXI-Lite address width; taken from request beat0 tdata[ADDR_WIDTH-1:0].
- TIMEOUT_CYC, 1023, cycles to wait for bvalid/rvalid before forcing completion.

Ports:
- axi_clk  in  1  clock
- axi_reset_n  in  1  synchronous active-low reset
- s_tvalid / s_tready  in / out  1 / 1  request stream handshake
- s_tdata  in  32  beat0: [31:28] wstrb, [ADDR_WIDTH-1:0] address; beat1: write data
- s_tuser  in  2  beat0 type: 2'b01 write, 2'b10 read; any other value is invalid
- s_tlast  in  1  end of packet
- m_awvalid, m_awready, m_awaddr  out, in, out  1, 1, ADDR_WIDTH  write address channel
- m_wvalid, m_wready, m_wdata, m_wstrb  out, in, out, out  1, 1, 32, 4  write data channel
- m_bvalid, m_bready  in, out  1, 1  write response (bresp not used)
- m_arvalid, m_arready, m_araddr  out, in, out  1, 1, ADDR_WIDTH  read address channel
- m_rvalid, m_rready, m_rdata  in, out, in  1, 1, 32  read data channel
- c_tvalid, c_tready, c_tdata, c_tuser, c_tlast  out, in, out, out, out  1, 1, 32, 2, 1  completion stream
- err_cnt  out  8  saturating count of malformed packets and timeouts
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all valid/ready outputs 0, all address/data/strb outputs 0, c_tuser 0, c_tlast 0, err_cnt 0, FSM in IDLE.
- Reset asserted mid-transaction abandons it; no completion is sent.
- FSM states: IDLE, WR_BEAT, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, CPL, DRAIN.
- IDLE:
  - s_tready=1.
  - Accepted beat with tuser=01 and tlast=0: latch address and wstrb, go to WR_BEAT.
  - tuser=10 and tlast=1: latch address, go to RD_ISSUE.
  - Any other combination (bad tuser; write with tlast=1; read with tlast=0): err_cnt++. Go to DRAIN if tlast=0, else stay in IDLE.
- WR_BEAT:
  - s_tready=1; on accept, latch wdata.
  - tlast=1: go to WR_ISSUE.
  - tlast=0: err_cnt++, go to DRAIN; no AXI-Lite access is made.
- WR_ISSUE:
  - awvalid and wvalid both rise in the cycle after entry.
  - Each drops independently on its own handshake; the two may complete in either order or in the same cycle.
  - After both are done, go to WR_RESP.
- WR_RESP: bready=1; on bvalid go to IDLE. Writes send no completion.
- RD_ISSUE: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready=1; on rvalid, latch rdata into c_tdata.
  - Set c_tuser=2'b11, c_tlast=1, go to CPL.
- CPL: c_tvalid=1, holding data stable until c_tready; then go to IDLE.
- DRAIN: s_tready=1; discard beats through the one with tlast=1, then go to IDLE.
- s_tready is 0 in WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA and CPL.
- Timeout:
  - A 10-bit counter clears on entry to WR_RESP or RD_DATA and increments each cycle while waiting.
  - When it reaches TIMEOUT_CYC: err_cnt++.
  - In WR_RESP, go to IDLE.
  - In RD_DATA, set c_tdata=32'hDEAD_BEEF, c_tuser=2'b10, go to CPL.
- err_cnt saturates at 255.
- Minimum latency:
  - Read request accepted in cycle N gives arvalid at N+1.
  - With zero-wait slaves, c_tvalid is asserted at N+3.

Decomposition:
- Package axis_axil_pkg holds:
  - the tuser encodings TU_WR=2'b01, TU_RD=2'b10, TU_CPL=2'b11, TU_CPL_ERR=2'b10;
  - the state enum;
  - the constants WSTRB_MSB=31, WSTRB_LSB=28 and DEAD_DATA=32'hDEAD_BEEF.
- One natural sub-module: axis_axil_tmo, the timeout counter, with inputs start, wait_active and outputs expired.

Test Plan:
- Write beat0 {4'hF, addr 15'h0100}, tuser=01, then beat1 32'h1234_5678 with tlast=1; zero-wait slave -> awaddr=0x100, wdata=0x12345678, wstrb=4'hF, exactly one B handshake, no c_tvalid.
- Read addr 0x0204 with slave rdata=32'hCAFE_F00D and rvalid delayed 5 cycles -> exactly one completion beat: tdata=0xCAFEF00D, tuser=11, tlast=1.
- Same read with c_tready held 0 for 10 cycles -> c_tdata stable for all 10 cycles, s_tready=0 throughout.
- Write slave with awready delayed 3 cycles and wready immediate, then the reverse -> both transactions complete, and the second request is not accepted before bvalid.
- tuser=2'b00 beat with tlast=0, followed by 2 beats ending with tlast=1 -> err_cnt=1, no AXI-Lite activity, next valid read executes normally.
- Read with rvalid never asserted -> after 1023 cycles in RD_DATA, completion tdata=0xDEADBEEF, tuser=10, err_cnt=1.

Source files
------------

// File: rtl/axis_axil_pkg.sv
// Shared encodings, constants and the FSM state type for the
// stream-to-AXI-Lite request replay stage.
package axis_axil_pkg;

  // Request beat0 type codes and completion type codes on tuser.
  localparam logic [1:0] TU_WR      = 2'b01;
  localparam logic [1:0] TU_RD      = 2'b10;
  localparam logic [1:0] TU_CPL     = 2'b11;
  localparam logic [1:0] TU_CPL_ERR = 2'b10;

  // Location of the byte strobes inside request beat0.
  localparam int WSTRB_MSB = 31;
  localparam int WSTRB_LSB = 28;

  // Payload returned when a read never receives rvalid.
  localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BEAT,
    ST_WR_ISSUE,
    ST_WR_RESP,
    ST_RD_ISSUE,
    ST_RD_DATA,
    ST_CPL,
    ST_DRAIN
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axis_axil_master_if.sv
// Bundle of the request stream, the AXI-Lite master bus and the
// completion stream. The master modport is the bridge stage itself,
// the slave modport is whatever sits around it.
interface axis_axil_master_if #(
  parameter int ADDR_WIDTH = 15
);
  // request stream
  logic                  s_tvalid;
  logic                  s_tready;
  logic [31:0]           s_tdata;
  logic [1:0]            s_tuser;
  logic                  s_tlast;
  // AXI-Lite write address / data / response
  logic                  m_awvalid;
  logic                  m_awready;
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic                  m_bvalid;
  logic                  m_bready;
  // AXI-Lite read address / data
  logic                  m_arvalid;
  logic                  m_arready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [31:0]           m_rdata;
  // completion stream
  logic                  c_tvalid;
  logic                  c_tready;
  logic [31:0]           c_tdata;
  logic [1:0]            c_tuser;
  logic                  c_tlast;

  modport master (
    input  s_tvalid, s_tdata, s_tuser, s_tlast,
    output s_tready,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_awready, m_wready, m_bvalid,
    output m_arvalid, m_araddr, m_rready,
    input  m_arready, m_rvalid, m_rdata,
    output c_tvalid, c_tdata, c_tuser, c_tlast,
    input  c_tready
  );

  modport slave (
    output s_tvalid, s_tdata, s_tuser, s_tlast,
    input  s_tready,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_awready, m_wready, m_bvalid,
    input  m_arvalid, m_araddr, m_rready,
    output m_arready, m_rvalid, m_rdata,
    input  c_tvalid, c_tdata, c_tuser, c_tlast,
    output c_tready
  );

endinterface

// File: rtl/axis_axil_tmo.sv
// Response watchdog: restarts from zero on start, counts while the
// FSM waits for a slave response, and flags expiry at the limit.
module axis_axil_tmo #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic axi_clk,
  input  logic axi_reset_n,
  input  logic start,
  input  logic wait_active,
  output logic expired
);

  localparam logic [9:0] LIMIT = 10'(TIMEOUT_CYC);

  logic [9:0] cnt_reg;

  // Count waiting cycles; hold at the limit so expiry stays visible.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= '0;
    end else if (wait_active && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + 10'd1;
    end
  end

  assign expired = wait_active && (cnt_reg == LIMIT);

endmodule

// File: rtl/axis_axil_master.sv
// Replays request packets from the bridge stream as single AXI-Lite
// transactions and returns read data as one-beat completions. Only one
// transaction is in flight; the request stream stalls while busy.
module axis_axil_master
  import axis_axil_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                axi_clk,
  input  logic                axi_reset_n,
  axis_axil_master_if.master  bus,
  output logic [7:0]          err_cnt,
  output logic                busy
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [3:0]            wstrb_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           cdata_reg;
  logic [1:0]            cuser_reg;
  logic                  clast_reg;
  logic                  aw_done_reg, w_done_reg;
  logic [7:0]            err_cnt_reg;

  logic s_ready_c, awvalid_c, wvalid_c, bready_c, arvalid_c, rready_c, cvalid_c;
  logic load_addr, load_wstrb, load_wdata, load_rdata, load_dead, err_inc;
  logic tmo_start, tmo_wait, tmo_expired;

  // State register.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) state_reg <= ST_IDLE;
    else              state_reg <= state_next;
  end

  // Next-state, handshake outputs and datapath load strobes.
  always_comb begin
    state_next = state_reg;
    s_ready_c  = 1'b0;
    awvalid_c  = 1'b0;
    wvalid_c   = 1'b0;
    bready_c   = 1'b0;
    arvalid_c  = 1'b0;
    rready_c   = 1'b0;
    cvalid_c   = 1'b0;
    load_addr  = 1'b0;
    load_wstrb = 1'b0;
    load_wdata = 1'b0;
    load_rdata = 1'b0;
    load_dead  = 1'b0;
    err_inc    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        s_ready_c = 1'b1;
        if (bus.s_tvalid) begin
          if (bus.s_tuser == TU_WR && !bus.s_tlast) begin
            load_addr  = 1'b1;
            load_wstrb = 1'b1;
            state_next = ST_WR_BEAT;
          end else if (bus.s_tuser == TU_RD && bus.s_tlast) begin
            load_addr  = 1'b1;
            state_next = ST_RD_ISSUE;
          end else begin
            // Malformed head: drop the rest of the packet if any remains.
            err_inc    = 1'b1;
            state_next = bus.s_tlast ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_WR_BEAT: begin
        s_ready_c = 1'b1;
        if (bus.s_tvalid) begin
          load_wdata = 1'b1;
          if (bus.s_tlast) begin
            state_next = ST_WR_ISSUE;
          end else begin
            err_inc    = 1'b1;
            state_next = ST_DRAIN;
          end
        end
      end
      ST_WR_ISSUE: begin
        // AW and W complete independently; leave once both have.
        awvalid_c = !aw_done_reg;
        wvalid_c  = !w_done_reg;
        if ((aw_done_reg || bus.m_awready) && (w_done_reg || bus.m_wready))
          state_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        bready_c = 1'b1;
        if (bus.m_bvalid) begin
          state_next = ST_IDLE;
        end else if (tmo_expired) begin
          err_inc    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        arvalid_c = 1'b1;
        if (bus.m_arready) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rready_c = 1'b1;
        if (bus.m_rvalid) begin
          load_rdata = 1'b1;
          state_next = ST_CPL;
        end else if (tmo_expired) begin
          err_inc    = 1'b1;
          load_dead  = 1'b1;
          state_next = ST_CPL;
        end
      end
      ST_CPL: begin
        cvalid_c = 1'b1;
        if (bus.c_tready) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        s_ready_c = 1'b1;
        if (bus.s_tvalid && bus.s_tlast) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields and completion payload registers.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      addr_reg  <= '0;
      wstrb_reg <= '0;
      wdata_reg <= '0;
      cdata_reg <= '0;
      cuser_reg <= '0;
      clast_reg <= 1'b0;
    end else begin
      if (load_addr)  addr_reg  <= bus.s_tdata[ADDR_WIDTH-1:0];
      if (load_wstrb) wstrb_reg <= bus.s_tdata[WSTRB_MSB:WSTRB_LSB];
      if (load_wdata) wdata_reg <= bus.s_tdata;
      if (load_rdata) begin
        cdata_reg <= bus.m_rdata;
        cuser_reg <= TU_CPL;
        clast_reg <= 1'b1;
      end else if (load_dead) begin
        cdata_reg <= DEAD_DATA;
        cuser_reg <= TU_CPL_ERR;
        clast_reg <= 1'b1;
      end
    end
  end

  // Per-channel done flags for the write issue phase.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n || state_next != ST_WR_ISSUE) begin
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      if (awvalid_c && bus.m_awready) aw_done_reg <= 1'b1;
      if (wvalid_c && bus.m_wready)   w_done_reg  <= 1'b1;
    end
  end

  // Saturating error counter.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n)  err_cnt_reg <= '0;
    else if (err_inc)  err_cnt_reg <= sat_inc(err_cnt_reg);
  end

  assign tmo_start = (state_next == ST_WR_RESP && state_reg != ST_WR_RESP) ||
                     (state_next == ST_RD_DATA && state_reg != ST_RD_DATA);
  assign tmo_wait  = (state_reg == ST_WR_RESP) || (state_reg == ST_RD_DATA);

  axis_axil_tmo #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .start       (tmo_start),
    .wait_active (tmo_wait),
    .expired     (tmo_expired)
  );

  // Handshakes are forced low while reset is held so nothing is offered
  // or accepted during reset, including s_tready which IDLE would raise.
  assign bus.s_tready  = s_ready_c && axi_reset_n;
  assign bus.m_awvalid = awvalid_c && axi_reset_n;
  assign bus.m_wvalid  = wvalid_c  && axi_reset_n;
  assign bus.m_bready  = bready_c  && axi_reset_n;
  assign bus.m_arvalid = arvalid_c && axi_reset_n;
  assign bus.m_rready  = rready_c  && axi_reset_n;
  assign bus.c_tvalid  = cvalid_c  && axi_reset_n;

  assign bus.m_awaddr = addr_reg;
  assign bus.m_araddr = addr_reg;
  assign bus.m_wdata  = wdata_reg;
  assign bus.m_wstrb  = wstrb_reg;
  assign bus.c_tdata  = cdata_reg;
  assign bus.c_tuser  = cuser_reg;
  assign bus.c_tlast  = clast_reg;

  assign err_cnt = err_cnt_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_axis_axil_master.sv
// Directed bench for axis_axil_master: request driver, delay-programmable
// AXI-Lite slave, completion sink with back-pressure, and a bus monitor.
module tb_axis_axil_master;

  localparam int AW = 15;

  logic       axi_clk = 1'b0;
  logic       axi_reset_n = 1'b0;
  logic [7:0] err_cnt;
  logic       busy;

  axis_axil_master_if #(.ADDR_WIDTH(AW)) bus_if ();

  axis_axil_master #(
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CYC (1023)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .bus         (bus_if),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  always #5 axi_clk = ~axi_clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // slave / sink knobs (r_delay < 0 means rvalid never comes)
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0, c_delay = 0;
  logic [31:0] rdata_val = 32'h0;

  // monitor results
  int cyc = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, cpl_cnt = 0;
  int b_cyc = -1, ar_cyc = -1, ar_rise = -1, c_rise = -1;
  logic ar_prev = 1'b0, c_prev = 1'b0;
  logic [AW-1:0] aw_addr_seen = '0, ar_addr_seen = '0;
  logic [31:0]   wdata_seen = '0, cpl_data = '0;
  logic [3:0]    wstrb_seen = '0;
  logic [1:0]    cpl_user = '0;
  logic          cpl_last = 1'b0;

  initial forever begin
    @(posedge axi_clk);
    cyc++;
  end

  // AXI-Lite slave and completion sink, updated just after each edge.
  initial begin
    int aw_w, w_w, b_w, ar_w, r_w, c_w;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; c_w = 0;
    bus_if.m_awready = 1'b0;
    bus_if.m_wready  = 1'b0;
    bus_if.m_bvalid  = 1'b0;
    bus_if.m_arready = 1'b0;
    bus_if.m_rvalid  = 1'b0;
    bus_if.m_rdata   = 32'h0;
    bus_if.c_tready  = 1'b0;
    forever begin
      @(posedge axi_clk);
      #1;
      if (bus_if.m_awvalid) begin
        if (aw_w >= aw_delay) bus_if.m_awready = 1'b1;
        else begin bus_if.m_awready = 1'b0; aw_w++; end
      end else begin bus_if.m_awready = 1'b0; aw_w = 0; end
      if (bus_if.m_wvalid) begin
        if (w_w >= w_delay) bus_if.m_wready = 1'b1;
        else begin bus_if.m_wready = 1'b0; w_w++; end
      end else begin bus_if.m_wready = 1'b0; w_w = 0; end
      if (bus_if.m_bready) begin
        if (b_w >= b_delay) bus_if.m_bvalid = 1'b1;
        else begin bus_if.m_bvalid = 1'b0; b_w++; end
      end else begin bus_if.m_bvalid = 1'b0; b_w = 0; end
      if (bus_if.m_arvalid) begin
        if (ar_w >= ar_delay) bus_if.m_arready = 1'b1;
        else begin bus_if.m_arready = 1'b0; ar_w++; end
      end else begin bus_if.m_arready = 1'b0; ar_w = 0; end
      if (bus_if.m_rready) begin
        if (r_delay >= 0 && r_w >= r_delay) begin
          bus_if.m_rvalid = 1'b1;
          bus_if.m_rdata  = rdata_val;
        end else begin bus_if.m_rvalid = 1'b0; r_w++; end
      end else begin bus_if.m_rvalid = 1'b0; r_w = 0; end
      if (bus_if.c_tvalid) begin
        if (c_w >= c_delay) bus_if.c_tready = 1'b1;
        else begin bus_if.c_tready = 1'b0; c_w++; end
      end else begin bus_if.c_tready = 1'b0; c_w = 0; end
    end
  end

  // Bus monitor, sampled mid-cycle.
  initial forever begin
    @(negedge axi_clk);
    if (bus_if.m_awvalid && bus_if.m_awready) begin aw_cnt++; aw_addr_seen = bus_if.m_awaddr; end
    if (bus_if.m_wvalid && bus_if.m_wready) begin
      w_cnt++; wdata_seen = bus_if.m_wdata; wstrb_seen = bus_if.m_wstrb;
    end
    if (bus_if.m_bvalid && bus_if.m_bready) begin b_cnt++; b_cyc = cyc; end
    if (bus_if.m_arvalid && bus_if.m_arready) begin
      ar_cnt++; ar_addr_seen = bus_if.m_araddr; ar_cyc = cyc;
    end
    if (bus_if.c_tvalid && bus_if.c_tready) begin
      cpl_cnt++; cpl_data = bus_if.c_tdata; cpl_user = bus_if.c_tuser; cpl_last = bus_if.c_tlast;
    end
    if (bus_if.m_arvalid && !ar_prev) ar_rise = cyc;
    if (bus_if.c_tvalid && !c_prev) c_rise = cyc;
    ar_prev = bus_if.m_arvalid;
    c_prev  = bus_if.c_tvalid;
  end

  // Offer one request beat (call just after a rising edge); acc gets the
  // cycle in which it was accepted, -1 if never.
  task automatic send_beat(input logic [31:0] d, input logic [1:0] u, input logic l,
                           output int acc);
    int n;
    bus_if.s_tvalid = 1'b1;
    bus_if.s_tdata  = d;
    bus_if.s_tuser  = u;
    bus_if.s_tlast  = l;
    acc = -1;
    n = 0;
    while (acc < 0 && n < 3000) begin
      @(negedge axi_clk);
      if (bus_if.s_tready) acc = cyc;
      n++;
    end
    total_cnt++;
    if (acc < 0) $display("FAIL send_beat: s_tready stayed 0 for %0d cycles, required 1", n);
    else pass_cnt++;
    @(posedge axi_clk);
    #1;
    bus_if.s_tvalid = 1'b0;
    bus_if.s_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge axi_clk);
      n++;
    end while (busy && n < 3000);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
    else pass_cnt++;
    @(posedge axi_clk);
    #1;
  endtask

  // Wait for c_tvalid; returns the cycle it was first seen, -1 on timeout.
  task automatic wait_cvalid(input string tag, output int seen, output logic s_rdy_seen);
    int n;
    n = 0;
    seen = -1;
    s_rdy_seen = 1'b0;
    while (seen < 0 && n < 2000) begin
      @(negedge axi_clk);
      if (bus_if.s_tready) s_rdy_seen = 1'b1;
      if (bus_if.c_tvalid) seen = cyc;
      n++;
    end
    total_cnt++;
    if (seen < 0) $display("FAIL %s_cvalid: c_tvalid=0 after %0d cycles, required 1", tag, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    axi_reset_n = 1'b0;
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    total_cnt++;
    if ({bus_if.s_tready, bus_if.m_awvalid, bus_if.m_wvalid, bus_if.m_bready,
         bus_if.m_arvalid, bus_if.m_rready, bus_if.c_tvalid} !== 7'b0)
      $display("FAIL reset_handshakes: got %b required 0000000",
               {bus_if.s_tready, bus_if.m_awvalid, bus_if.m_wvalid, bus_if.m_bready,
                bus_if.m_arvalid, bus_if.m_rready, bus_if.c_tvalid});
    else pass_cnt++;
    total_cnt++;
    if ({bus_if.m_awaddr, bus_if.m_araddr, bus_if.m_wdata, bus_if.m_wstrb} !== '0)
      $display("FAIL reset_addr_data: awaddr=%h araddr=%h wdata=%h wstrb=%h required 0",
               bus_if.m_awaddr, bus_if.m_araddr, bus_if.m_wdata, bus_if.m_wstrb);
    else pass_cnt++;
    total_cnt++;
    if ({bus_if.c_tdata, bus_if.c_tuser, bus_if.c_tlast} !== 35'h0)
      $display("FAIL reset_cpl: tdata=%h tuser=%b tlast=%b required 0",
               bus_if.c_tdata, bus_if.c_tuser, bus_if.c_tlast);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt !== 8'd0 || busy !== 1'b0)
      $display("FAIL reset_status: err_cnt=%0d busy=%b required 0/0", err_cnt, busy);
    else pass_cnt++;
    @(posedge axi_clk);
    #1;
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    total_cnt++;
    if (bus_if.s_tready !== 1'b1) $display("FAIL reset_release_tready: got %b required 1", bus_if.s_tready);
    else pass_cnt++;
    @(posedge axi_clk);
    #1;
  endtask

  task automatic test_write();
    int a, aw0, w0, b0, c0;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; c0 = cpl_cnt;
    send_beat({4'hF, 13'h0, 15'h0100}, 2'b01, 1'b0, a);
    send_beat(32'h1234_5678, 2'b01, 1'b1, a);
    wait_idle("write");
    repeat (4) @(posedge axi_clk);
    #1;
    total_cnt++;
    if (aw_cnt - aw0 != 1 || aw_addr_seen !== 15'h0100)
      $display("FAIL write_aw: count=%0d awaddr=%h required 1/0100", aw_cnt - aw0, aw_addr_seen);
    else pass_cnt++;
    total_cnt++;
    if (w_cnt - w0 != 1 || wdata_seen !== 32'h1234_5678 || wstrb_seen !== 4'hF)
      $display("FAIL write_w: count=%0d wdata=%h wstrb=%h required 1/12345678/f",
               w_cnt - w0, wdata_seen, wstrb_seen);
    else pass_cnt++;
    total_cnt++;
    if (b_cnt - b0 != 1) $display("FAIL write_b_count: got %0d required 1", b_cnt - b0);
    else pass_cnt++;
    total_cnt++;
    if (cpl_cnt - c0 != 0) $display("FAIL write_no_cpl: got %0d completions required 0", cpl_cnt - c0);
    else pass_cnt++;
    $display("write addr=%h data=%h strb=%h b=%0d", aw_addr_seen, wdata_seen, wstrb_seen, b_cnt - b0);
  endtask

  task automatic test_read();
    int a, c0, ar0;
    c0 = cpl_cnt; ar0 = ar_cnt;
    r_delay = 5; rdata_val = 32'hCAFE_F00D;
    send_beat({17'h0, 15'h0204}, 2'b10, 1'b1, a);
    wait_idle("read");
    total_cnt++;
    if (ar_cnt - ar0 != 1 || ar_addr_seen !== 15'h0204)
      $display("FAIL read_ar: count=%0d araddr=%h required 1/0204", ar_cnt - ar0, ar_addr_seen);
    else pass_cnt++;
    total_cnt++;
    if (cpl_cnt - c0 != 1) $display("FAIL read_cpl_count: got %0d required 1", cpl_cnt - c0);
    else pass_cnt++;
    total_cnt++;
    if (cpl_data !== 32'hCAFE_F00D || cpl_user !== 2'b11 || cpl_last !== 1'b1)
      $display("FAIL read_cpl_beat: tdata=%h tuser=%b tlast=%b required cafef00d/11/1",
               cpl_data, cpl_user, cpl_last);
    else pass_cnt++;
    $display("read addr=%h cpl=%h user=%b", ar_addr_seen, cpl_data, cpl_user);
    r_delay = 0;
  endtask

  task automatic test_latency();
    int a;
    r_delay = 0; rdata_val = 32'h0000_00A5;
    send_beat({17'h0, 15'h0010}, 2'b10, 1'b1, a);
    wait_idle("latency");
    total_cnt++;
    if (ar_rise != a + 1) $display("FAIL latency_arvalid: got cycle %0d required %0d", ar_rise, a + 1);
    else pass_cnt++;
    total_cnt++;
    if (c_rise != a + 3) $display("FAIL latency_ctvalid: got cycle %0d required %0d", c_rise, a + 3);
    else pass_cnt++;
    $display("latency accept=%0d arvalid=%0d ctvalid=%0d", a, ar_rise, c_rise);
  endtask

  task automatic test_backpressure();
    int a, seen, bad, c0;
    logic srdy;
    c0 = cpl_cnt;
    r_delay = 5; c_delay = 10; rdata_val = 32'hCAFE_F00D;
    send_beat({17'h0, 15'h0204}, 2'b10, 1'b1, a);
    wait_cvalid("bp", seen, srdy);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.c_tvalid !== 1'b1 || bus_if.c_tdata !== 32'hCAFE_F00D || bus_if.c_tuser !== 2'b11) bad++;
      if (bus_if.s_tready !== 1'b0) srdy = 1'b1;
      if (i < 9) @(negedge axi_clk);
    end
    total_cnt++;
    if (bad != 0) $display("FAIL bp_stable: %0d of 10 stalled cycles changed, required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (srdy !== 1'b0) $display("FAIL bp_s_tready: s_tready seen %b while busy, required 0", srdy);
    else pass_cnt++;
    @(posedge axi_clk);
    #1;
    wait_idle("bp");
    total_cnt++;
    if (cpl_cnt - c0 != 1) $display("FAIL bp_cpl_count: got %0d required 1", cpl_cnt - c0);
    else pass_cnt++;
    $display("backpressure cpl=%h stalled_bad=%0d", cpl_data, bad);
    r_delay = 0; c_delay = 0;
  endtask

  task automatic test_back_to_back();
    int a, acc2, b0;
    b0 = b_cnt;
    aw_delay = 3; w_delay = 0; b_delay = 2;
    send_beat({4'h3, 13'h0, 15'h0300}, 2'b01, 1'b0, a);
    send_beat(32'hA5A5_0001, 2'b01, 1'b1, a);
    send_beat({4'hC, 13'h0, 15'h0304}, 2'b01, 1'b0, acc2);
    total_cnt++;
    if (b_cnt - b0 != 1 || acc2 <= b_cyc)
      $display("FAIL b2b_order: b=%0d bcyc=%0d accept=%0d required b=1 and accept after bcyc",
               b_cnt - b0, b_cyc, acc2);
    else pass_cnt++;
    total_cnt++;
    if (aw_addr_seen !== 15'h0300 || wdata_seen !== 32'hA5A5_0001 || wstrb_seen !== 4'h3)
      $display("FAIL b2b_first: awaddr=%h wdata=%h wstrb=%h required 0300/a5a50001/3",
               aw_addr_seen, wdata_seen, wstrb_seen);
    else pass_cnt++;
    aw_delay = 0; w_delay = 3;
    send_beat(32'h5A5A_0002, 2'b01, 1'b1, a);
    wait_idle("b2b");
    total_cnt++;
    if (b_cnt - b0 != 2) $display("FAIL b2b_b_count: got %0d required 2", b_cnt - b0);
    else pass_cnt++;
    total_cnt++;
    if (aw_addr_seen !== 15'h0304 || wdata_seen !== 32'h5A5A_0002 || wstrb_seen !== 4'hC)
      $display("FAIL b2b_second: awaddr=%h wdata=%h wstrb=%h required 0304/5a5a0002/c",
               aw_addr_seen, wdata_seen, wstrb_seen);
    else pass_cnt++;
    $display("back_to_back b=%0d second_accept=%0d first_b=%0d", b_cnt - b0, acc2, b_cyc);
    aw_delay = 0; w_delay = 0; b_delay = 0;
  endtask

  task automatic test_malformed();
    int a, aw0, w0, ar0;
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
    send_beat(32'h0000_0100, 2'b00, 1'b0, a);
    send_beat(32'h1111_1111, 2'b01, 1'b0, a);
    send_beat(32'h2222_2222, 2'b10, 1'b1, a);
    repeat (3) @(posedge axi_clk);
    #1;
    total_cnt++;
    if (err_cnt !== 8'd1) $display("FAIL bad_err_cnt: got %0d required 1", err_cnt);
    else pass_cnt++;
    total_cnt++;
    if (aw_cnt != aw0 || w_cnt != w0 || ar_cnt != ar0 || busy !== 1'b0)
      $display("FAIL bad_no_access: aw=%0d w=%0d ar=%0d busy=%b required 0/0/0/0",
               aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0, busy);
    else pass_cnt++;
    rdata_val = 32'h0BAD_F00D;
    send_beat({17'h0, 15'h0040}, 2'b10, 1'b1, a);
    wait_idle("bad_read");
    total_cnt++;
    if (ar_addr_seen !== 15'h0040 || cpl_data !== 32'h0BAD_F00D || cpl_user !== 2'b11)
      $display("FAIL bad_next_read: araddr=%h tdata=%h tuser=%b required 0040/0badf00d/11",
               ar_addr_seen, cpl_data, cpl_user);
    else pass_cnt++;
    $display("malformed err_cnt=%0d next_read=%h", err_cnt, cpl_data);
  endtask

  task automatic test_timeout();
    int a, seen;
    logic srdy;
    r_delay = -1;
    send_beat({17'h0, 15'h0008}, 2'b10, 1'b1, a);
    wait_cvalid("tmo", seen, srdy);
    total_cnt++;
    if (bus_if.c_tdata !== 32'hDEAD_BEEF || bus_if.c_tuser !== 2'b10 || bus_if.c_tlast !== 1'b1)
      $display("FAIL tmo_cpl: tdata=%h tuser=%b tlast=%b required deadbeef/10/1",
               bus_if.c_tdata, bus_if.c_tuser, bus_if.c_tlast);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt !== 8'd2) $display("FAIL tmo_err_cnt: got %0d required 2", err_cnt);
    else pass_cnt++;
    total_cnt++;
    if (seen - ar_cyc < 1024 || seen - ar_cyc > 1026)
      $display("FAIL tmo_wait: %0d cycles from AR to completion, required 1024..1026", seen - ar_cyc);
    else pass_cnt++;
    @(posedge axi_clk);
    #1;
    wait_idle("tmo");
    $display("timeout cpl=%h err_cnt=%0d wait=%0d", cpl_data, err_cnt, seen - ar_cyc);
    r_delay = 0;
  endtask

  task automatic test_reset_abort();
    int a, c0;
    c0 = cpl_cnt;
    r_delay = -1;
    send_beat({17'h0, 15'h0008}, 2'b10, 1'b1, a);
    repeat (20) @(posedge axi_clk);
    #1;
    axi_reset_n = 1'b0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    total_cnt++;
    if (busy !== 1'b0 || bus_if.m_rready !== 1'b0 || bus_if.c_tvalid !== 1'b0)
      $display("FAIL abort_in_reset: busy=%b rready=%b ctvalid=%b required 0/0/0",
               busy, bus_if.m_rready, bus_if.c_tvalid);
    else pass_cnt++;
    @(posedge axi_clk);
    #1;
    axi_reset_n = 1'b1;
    repeat (5) @(posedge axi_clk);
    @(negedge axi_clk);
    total_cnt++;
    if (cpl_cnt != c0 || err_cnt !== 8'd0 || bus_if.s_tready !== 1'b1)
      $display("FAIL abort_after: cpl=%0d err_cnt=%0d s_tready=%b required 0/0/1",
               cpl_cnt - c0, err_cnt, bus_if.s_tready);
    else pass_cnt++;
    $display("reset_abort cpl=%0d err_cnt=%0d", cpl_cnt - c0, err_cnt);
    r_delay = 0;
    @(posedge axi_clk);
    #1;
  endtask

  initial begin
    bus_if.s_tvalid = 1'b0;
    bus_if.s_tdata  = 32'h0;
    bus_if.s_tuser  = 2'b00;
    bus_if.s_tlast  = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_malformed();
    test_timeout();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
